// File: rtl/peripheral_msi_master_port_ahb3.sv
// AHB3-Lite master port: routes each master transfer to one of SLAVES slave ports; 0 added cycles when granted.
// Backpressure: a held transfer is replayed until its slave port grants; unmapped addresses get a 2-cycle ERROR.
module peripheral_msi_master_port_ahb3 #(
   parameter int PLEN   = 64,
   parameter int XLEN   = 64,
   parameter int SLAVES = 5
) (
   input  logic              HRESETn,
   input  logic              HCLK,

   input  logic              mstHSEL,
   input  logic [PLEN-1:0]   mstHADDR,
   input  logic [XLEN-1:0]   mstHWDATA,
   output logic [XLEN-1:0]   mstHRDATA,
   input  logic              mstHWRITE,
   input  logic [2:0]        mstHSIZE,
   input  logic [2:0]        mstHBURST,
   input  logic [3:0]        mstHPROT,
   input  logic [1:0]        mstHTRANS,
   input  logic              mstHMASTLOCK,
   output logic              mstHREADYOUT,
   input  logic              mstHREADY,
   output logic              mstHRESP,

   input  logic [PLEN-1:0]   slvHADDRbase [SLAVES],
   input  logic [PLEN-1:0]   slvHADDRmask [SLAVES],
   output logic [SLAVES-1:0] slvHSEL,
   output logic [PLEN-1:0]   slvHADDR,
   output logic [XLEN-1:0]   slvHWDATA,
   input  logic [XLEN-1:0]   slvHRDATA [SLAVES],
   output logic              slvHWRITE,
   output logic [2:0]        slvHSIZE,
   output logic [2:0]        slvHBURST,
   output logic [3:0]        slvHPROT,
   output logic [1:0]        slvHTRANS,
   output logic              slvHMASTLOCK,
   output logic              slvHREADY,
   input  logic [SLAVES-1:0] slvHREADYOUT,
   input  logic [SLAVES-1:0] slvHRESP,

   input  logic [SLAVES-1:0] granted,
   output logic [SLAVES-1:0] can_switch
);

   localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;

   typedef enum logic [2:0] {NO_ACCESS, PENDING, DATA, ERR1, ERR2} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic            capture;
   logic            accept_en;
   logic            xfer;
   logic            pend;

   logic [PLEN-1:0] h_addr_q;
   logic            h_write_q;
   logic            h_lock_q;
   logic [2:0]      h_size_q;
   logic [2:0]      h_burst_q;
   logic [3:0]      h_prot_q;
   logic [1:0]      h_trans_q;

   logic [SLAVES-1:0] match;
   logic              tgt_vld;
   logic [SW-1:0]     tgt_idx;

   // Descending scan so the lowest matching slave index wins.
   always_comb begin
      match   = '0;
      tgt_vld = 1'b0;
      tgt_idx = '0;
      for (int s = SLAVES - 1; s >= 0; s--) begin
         match[s] = mstHSEL & (((mstHADDR ^ slvHADDRbase[s]) & slvHADDRmask[s]) == '0);
         if (match[s]) begin
            tgt_vld = 1'b1;
            tgt_idx = SW'(s);
         end
      end
   end

   assign xfer = mstHSEL & mstHTRANS[1];
   assign pend = (state_q == PENDING);

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      capture   = 1'b0;
      accept_en = 1'b0;
      unique case (state_q)
         NO_ACCESS, ERR2: accept_en = mstHREADY;
         DATA:            accept_en = mstHREADY & slvHREADYOUT[sel_q];
         PENDING:         if (granted[sel_q] & slvHREADYOUT[sel_q]) state_d = DATA;
         ERR1:            state_d = ERR2;
         default:         state_d = NO_ACCESS;
      endcase
      if (accept_en) begin
         if (!xfer) begin
            state_d = NO_ACCESS;
         end else if (!tgt_vld) begin
            state_d = ERR1;
         end else begin
            sel_d = tgt_idx;
            if (granted[tgt_idx]) begin
               state_d = DATA;
            end else begin
               state_d = PENDING;
               capture = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= NO_ACCESS;
         sel_q     <= '0;
         h_addr_q  <= '0;
         h_write_q <= 1'b0;
         h_lock_q  <= 1'b0;
         h_size_q  <= '0;
         h_burst_q <= '0;
         h_prot_q  <= '0;
         h_trans_q <= IDLE;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         if (capture) begin
            h_addr_q  <= mstHADDR;
            h_write_q <= mstHWRITE;
            h_lock_q  <= mstHMASTLOCK;
            h_size_q  <= mstHSIZE;
            h_burst_q <= mstHBURST;
            h_prot_q  <= mstHPROT;
            h_trans_q <= mstHTRANS;
         end
      end
   end

   // A held SEQ is replayed as NONSEQ: the slave port sees it as the start of a new access.
   always_comb begin
      slvHSEL = '0;
      if (pend) begin
         slvHADDR       = h_addr_q;
         slvHWRITE      = h_write_q;
         slvHSIZE       = h_size_q;
         slvHBURST      = h_burst_q;
         slvHPROT       = h_prot_q;
         slvHMASTLOCK   = h_lock_q;
         slvHTRANS      = (h_trans_q == SEQ) ? NONSEQ : h_trans_q;
         slvHSEL[sel_q] = 1'b1;
      end else begin
         slvHADDR     = mstHADDR;
         slvHWRITE    = mstHWRITE;
         slvHSIZE     = mstHSIZE;
         slvHBURST    = mstHBURST;
         slvHPROT     = mstHPROT;
         slvHMASTLOCK = mstHMASTLOCK;
         slvHTRANS    = mstHSEL ? mstHTRANS : IDLE;
         if (xfer & tgt_vld) slvHSEL[tgt_idx] = 1'b1;
      end
      if (!HRESETn) begin
         slvHSEL   = '0;
         slvHTRANS = IDLE;
      end
   end

   assign slvHWDATA = mstHWDATA;
   assign slvHREADY = mstHREADYOUT;

   always_comb begin
      can_switch = '1;
      if (HRESETn) begin
         if (pend) begin
            if (h_lock_q) can_switch[sel_q] = 1'b0;
         end else if (tgt_vld & (mstHMASTLOCK | (mstHTRANS == BUSY) | (mstHTRANS == SEQ))) begin
            can_switch[tgt_idx] = 1'b0;
         end
      end
   end

   always_comb begin
      mstHREADYOUT = 1'b1;
      mstHRESP     = 1'b0;
      mstHRDATA    = '0;
      unique case (state_q)
         PENDING: mstHREADYOUT = 1'b0;
         DATA: begin
            mstHREADYOUT = slvHREADYOUT[sel_q];
            mstHRESP     = slvHRESP[sel_q];
            mstHRDATA    = slvHRDATA[sel_q];
         end
         ERR1: begin
            mstHREADYOUT = 1'b0;
            mstHRESP     = 1'b1;
         end
         ERR2:    mstHRESP = 1'b1;
         default: mstHREADYOUT = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_peripheral_msi_master_port_ahb3.sv
// Bench for peripheral_msi_master_port_ahb3: decode vector table, directed corner sequences, random run vs model.
module tb_peripheral_msi_master_port_ahb3;
   localparam int PLEN = 64;
   localparam int XLEN = 64;
   localparam int NS   = 5;
   localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

   logic HRESETn, HCLK;
   logic mstHSEL, mstHWRITE, mstHMASTLOCK, mstHREADY, mstHREADYOUT, mstHRESP;
   logic [PLEN-1:0] mstHADDR;
   logic [XLEN-1:0] mstHWDATA, mstHRDATA;
   logic [2:0] mstHSIZE, mstHBURST;
   logic [3:0] mstHPROT;
   logic [1:0] mstHTRANS;
   logic [PLEN-1:0] slvHADDRbase [NS];
   logic [PLEN-1:0] slvHADDRmask [NS];
   logic [XLEN-1:0] slvHRDATA [NS];
   logic [NS-1:0] slvHSEL, slvHREADYOUT, slvHRESP, granted, can_switch;
   logic [PLEN-1:0] slvHADDR;
   logic [XLEN-1:0] slvHWDATA;
   logic slvHWRITE, slvHMASTLOCK, slvHREADY;
   logic [2:0] slvHSIZE, slvHBURST;
   logic [3:0] slvHPROT;
   logic [1:0] slvHTRANS;

   peripheral_msi_master_port_ahb3 #(.PLEN(PLEN), .XLEN(XLEN), .SLAVES(NS)) dut (
      .HRESETn(HRESETn), .HCLK(HCLK),
      .mstHSEL(mstHSEL), .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA), .mstHRDATA(mstHRDATA),
      .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE), .mstHBURST(mstHBURST), .mstHPROT(mstHPROT),
      .mstHTRANS(mstHTRANS), .mstHMASTLOCK(mstHMASTLOCK), .mstHREADYOUT(mstHREADYOUT),
      .mstHREADY(mstHREADY), .mstHRESP(mstHRESP),
      .slvHADDRbase(slvHADDRbase), .slvHADDRmask(slvHADDRmask), .slvHSEL(slvHSEL),
      .slvHADDR(slvHADDR), .slvHWDATA(slvHWDATA), .slvHRDATA(slvHRDATA), .slvHWRITE(slvHWRITE),
      .slvHSIZE(slvHSIZE), .slvHBURST(slvHBURST), .slvHPROT(slvHPROT), .slvHTRANS(slvHTRANS),
      .slvHMASTLOCK(slvHMASTLOCK), .slvHREADY(slvHREADY), .slvHREADYOUT(slvHREADYOUT),
      .slvHRESP(slvHRESP), .granted(granted), .can_switch(can_switch)
   );

   // Single-master bus: the master sees its own port's HREADYOUT.
   assign mstHREADY = mstHREADYOUT;

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic mst(input logic sel, input logic [1:0] tr, input logic [63:0] a,
                      input logic wr, input logic lk);
      mstHSEL = sel; mstHTRANS = tr; mstHADDR = a; mstHWRITE = wr; mstHMASTLOCK = lk;
   endtask

   task automatic go_idle();
      mst(1'b0, IDLE, 64'h0, 1'b0, 1'b0);
      granted = '1; slvHREADYOUT = '1; slvHRESP = '0;
      repeat (3) @(negedge HCLK);
   endtask

   function automatic int decode(input logic [63:0] a);
      for (int s = 0; s < NS; s++)
         if (((a ^ slvHADDRbase[s]) & slvHADDRmask[s]) == 64'h0) return s;
      return -1;
   endfunction

   typedef struct {
      logic        hsel;
      logic [1:0]  tr;
      logic        lk;
      logic [63:0] a;
      logic [4:0]  gnt;
      logic [4:0]  e_sel;
      logic [1:0]  e_tr;
      logic [4:0]  e_cs;
      logic        e_rdy;
      logic        e_resp;
   } vec_t;
   vec_t vt [10];

   // Reference model state (data-phase owner, held transfer, error phase).
   int          m_data, m_err, m_pt;
   bit          m_pend;
   logic [63:0] m_ha;
   logic        m_hw, m_hl;
   logic [1:0]  m_htr;

   initial begin
      HRESETn = 1'b0;
      for (int s = 0; s < NS; s++) begin
         slvHADDRbase[s] = 64'(s) << 28;
         slvHADDRmask[s] = 64'hF000_0000;
         slvHRDATA[s]    = 64'hA000 + 64'(s);
      end
      slvHADDRbase[3] = 64'h2000_0000;   // overlaps s2: s2 must win on 0x2xxx_xxxx
      slvHADDRmask[3] = 64'hE000_0000;
      mst(1'b0, IDLE, 64'h0, 1'b0, 1'b0);
      mstHWDATA = 64'h1234_5678_9ABC_DEF0; mstHSIZE = 3'd3; mstHBURST = 3'd0; mstHPROT = 4'b0011;
      granted = '1; slvHREADYOUT = '1; slvHRESP = '0;

      vt[0] = '{1'b1, NONSEQ, 1'b0, 64'h1000_0040, 5'b11111, 5'b00010, NONSEQ, 5'b11111, 1'b1, 1'b0};
      vt[1] = '{1'b1, NONSEQ, 1'b0, 64'h0000_0010, 5'b11110, 5'b00001, NONSEQ, 5'b11111, 1'b0, 1'b0};
      vt[2] = '{1'b1, NONSEQ, 1'b0, 64'hF000_0000, 5'b11111, 5'b00000, NONSEQ, 5'b11111, 1'b0, 1'b1};
      vt[3] = '{1'b0, NONSEQ, 1'b0, 64'h1000_0000, 5'b11111, 5'b00000, IDLE,   5'b11111, 1'b1, 1'b0};
      vt[4] = '{1'b1, SEQ,    1'b0, 64'h2000_0000, 5'b11111, 5'b00100, SEQ,    5'b11011, 1'b1, 1'b0};
      vt[5] = '{1'b1, SEQ,    1'b0, 64'h3000_0008, 5'b11111, 5'b01000, SEQ,    5'b10111, 1'b1, 1'b0};
      vt[6] = '{1'b1, BUSY,   1'b0, 64'h4000_0000, 5'b11111, 5'b00000, BUSY,   5'b01111, 1'b1, 1'b0};
      vt[7] = '{1'b1, NONSEQ, 1'b1, 64'h0000_0000, 5'b11111, 5'b00001, NONSEQ, 5'b11110, 1'b1, 1'b0};
      vt[8] = '{1'b1, IDLE,   1'b0, 64'h1000_0000, 5'b11111, 5'b00000, IDLE,   5'b11111, 1'b1, 1'b0};
      vt[9] = '{1'b1, NONSEQ, 1'b1, 64'h8000_0000, 5'b11111, 5'b00000, NONSEQ, 5'b11111, 1'b0, 1'b1};

      #2;
      chk("rst_sel", slvHSEL, 5'b0);
      chk("rst_trans", slvHTRANS, IDLE);
      chk("rst_rdy", mstHREADYOUT, 1'b1);
      chk("rst_resp", mstHRESP, 1'b0);
      chk("rst_rdata", mstHRDATA, 64'h0);
      chk("rst_cs", can_switch, 5'b11111);
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;

      for (int i = 0; i < 10; i++) begin
         go_idle();
         @(negedge HCLK);
         mst(vt[i].hsel, vt[i].tr, vt[i].a, 1'b0, vt[i].lk);
         granted = vt[i].gnt;
         #1;
         chk($sformatf("v%0d_sel", i), slvHSEL, vt[i].e_sel);
         chk($sformatf("v%0d_trans", i), slvHTRANS, vt[i].e_tr);
         chk($sformatf("v%0d_cs", i), can_switch, vt[i].e_cs);
         chk($sformatf("v%0d_addr", i), slvHADDR, vt[i].a);
         @(negedge HCLK);
         mst(1'b0, IDLE, 64'h0, 1'b0, 1'b0);
         #1;
         chk($sformatf("v%0d_rdy", i), mstHREADYOUT, vt[i].e_rdy);
         chk($sformatf("v%0d_resp", i), mstHRESP, vt[i].e_resp);
      end

      // Granted read: zero added latency, data routed from slave 1.
      go_idle();
      slvHRDATA[1] = 64'hDEAD_BEEF;
      @(negedge HCLK); mst(1'b1, NONSEQ, 64'h1000_0040, 1'b0, 1'b0); #1;
      chk("rd_sel", slvHSEL, 5'b00010);
      @(negedge HCLK); mst(1'b0, IDLE, 64'h0, 1'b0, 1'b0); #1;
      chk("rd_data", mstHRDATA, 64'hDEAD_BEEF);
      chk("rd_rdy", mstHREADYOUT, 1'b1);
      slvHRDATA[1] = 64'hA001;

      // Write held off by three ungranted cycles.
      go_idle();
      @(negedge HCLK); mst(1'b1, NONSEQ, 64'h0000_0010, 1'b1, 1'b0); granted = 5'b11110; #1;
      for (int w = 0; w < 3; w++) begin
         @(negedge HCLK);
         mst(1'b0, IDLE, 64'h0, 1'b0, 1'b0);
         if (w == 2) granted = 5'b11111;
         #1;
         chk($sformatf("ws%0d_rdy", w), mstHREADYOUT, 1'b0);
         chk($sformatf("ws%0d_addr", w), slvHADDR, 64'h0000_0010);
         chk($sformatf("ws%0d_sel", w), slvHSEL, 5'b00001);
         chk($sformatf("ws%0d_wr", w), slvHWRITE, 1'b1);
      end
      @(negedge HCLK); #1;
      chk("ws_done_rdy", mstHREADYOUT, 1'b1);

      // Default slave: two-cycle ERROR.
      go_idle();
      @(negedge HCLK); mst(1'b1, NONSEQ, 64'hF000_0000, 1'b0, 1'b0); #1;
      chk("err_sel0", slvHSEL, 5'b0);
      @(negedge HCLK); mst(1'b0, IDLE, 64'h0, 1'b0, 1'b0); #1;
      chk("err1_rdy", mstHREADYOUT, 1'b0);
      chk("err1_resp", mstHRESP, 1'b1);
      chk("err1_sel", slvHSEL, 5'b0);
      @(negedge HCLK); #1;
      chk("err2_rdy", mstHREADYOUT, 1'b1);
      chk("err2_resp", mstHRESP, 1'b1);
      @(negedge HCLK); #1;
      chk("err_end_resp", mstHRESP, 1'b0);

      // INCR4 crossing from s0 into ungranted s1.
      go_idle();
      granted = 5'b11101;
      @(negedge HCLK); mst(1'b1, NONSEQ, 64'h0FFF_FFF0, 1'b0, 1'b0); #1;
      chk("inc_b0_sel", slvHSEL, 5'b00001);
      @(negedge HCLK); mst(1'b1, SEQ, 64'h0FFF_FFF8, 1'b0, 1'b0); #1;
      chk("inc_b1_cs", can_switch, 5'b11110);
      @(negedge HCLK); mst(1'b1, SEQ, 64'h1000_0000, 1'b0, 1'b0); #1;
      chk("inc_b2_rdy", mstHREADYOUT, 1'b1);
      chk("inc_b2_cs", can_switch, 5'b11101);
      @(negedge HCLK); mst(1'b1, SEQ, 64'h1000_0008, 1'b0, 1'b0); #1;
      chk("inc_pend_rdy", mstHREADYOUT, 1'b0);
      chk("inc_pend_addr", slvHADDR, 64'h1000_0000);
      chk("inc_pend_sel", slvHSEL, 5'b00010);
      @(negedge HCLK); granted = 5'b11111; #1;
      chk("inc_gnt_trans", slvHTRANS, NONSEQ);
      chk("inc_gnt_rdy", mstHREADYOUT, 1'b0);
      @(negedge HCLK); #1;
      chk("inc_b3_rdy", mstHREADYOUT, 1'b1);
      chk("inc_b3_trans", slvHTRANS, SEQ);
      chk("inc_b3_cs", can_switch, 5'b11101);
      @(negedge HCLK); mst(1'b0, IDLE, 64'h0, 1'b0, 1'b0); #1;
      chk("inc_end_cs", can_switch, 5'b11111);

      // Locked transfer stuck in PENDING, then asynchronous reset.
      go_idle();
      granted = 5'b11110;
      @(negedge HCLK); mst(1'b1, NONSEQ, 64'h0000_0100, 1'b0, 1'b1); #1;
      chk("lk_cs_live", can_switch, 5'b11110);
      @(negedge HCLK); #1;
      chk("lk_cs_held", can_switch, 5'b11110);
      chk("lk_rdy", mstHREADYOUT, 1'b0);
      #2 HRESETn = 1'b0;
      #1;
      chk("lk_rst_sel", slvHSEL, 5'b0);
      chk("lk_rst_rdy", mstHREADYOUT, 1'b1);
      chk("lk_rst_cs", can_switch, 5'b11111);
      chk("lk_rst_trans", slvHTRANS, IDLE);
      @(negedge HCLK); mst(1'b0, IDLE, 64'h0, 1'b0, 1'b0); granted = '1;
      @(negedge HCLK); HRESETn = 1'b1;

      // Random run against the transaction-level model.
      go_idle();
      m_data = -1; m_err = 0; m_pend = 0; m_pt = 0; m_ha = '0; m_hw = 0; m_hl = 0; m_htr = IDLE;
      begin
         bit          acc;
         int          t, r;
         logic [4:0]  e_sel, e_cs;
         logic [1:0]  e_tr;
         logic [63:0] e_addr, e_rd;
         logic        e_rdy, e_resp, e_wr;
         acc = 1'b1;
         for (int c = 0; c < 1500; c++) begin
            @(negedge HCLK);
            if (acc) begin
               r = $urandom_range(0, 7);
               if (r >= 5) r = $urandom_range(5, 15);
               mstHSEL      = ($urandom_range(0, 7) != 0);
               mstHTRANS    = 2'($urandom_range(0, 3));
               mstHADDR     = {32'($urandom), 4'(r), 28'($urandom_range(0, 28'hFFF_FFFF))};
               mstHMASTLOCK = ($urandom_range(0, 5) == 0);
               mstHWRITE    = 1'($urandom_range(0, 1));
               mstHWDATA    = {32'($urandom), 32'($urandom)};
            end
            granted = 5'($urandom_range(0, 31));
            for (int s = 0; s < NS; s++) begin
               slvHREADYOUT[s] = ($urandom_range(0, 3) != 0);
               slvHRESP[s]     = ($urandom_range(0, 5) == 0);
               slvHRDATA[s]    = {32'($urandom), 32'($urandom)};
            end
            #1;
            t = mstHSEL ? decode(mstHADDR) : -1;
            e_cs = '1;
            if (m_pend) begin
               e_sel = 5'(1 << m_pt); e_addr = m_ha; e_tr = NONSEQ; e_wr = m_hw;
               if (m_hl) e_cs[m_pt] = 1'b0;
            end else begin
               e_sel  = (mstHSEL && mstHTRANS[1] && t >= 0) ? 5'(1 << t) : 5'b0;
               e_addr = mstHADDR; e_wr = mstHWRITE;
               e_tr   = mstHSEL ? mstHTRANS : IDLE;
               if (t >= 0 && (mstHMASTLOCK || mstHTRANS == BUSY || mstHTRANS == SEQ)) e_cs[t] = 1'b0;
            end
            e_rdy = 1'b1; e_resp = 1'b0; e_rd = '0;
            if (m_pend) e_rdy = 1'b0;
            else if (m_err == 1) begin e_rdy = 1'b0; e_resp = 1'b1; end
            else if (m_err == 2) e_resp = 1'b1;
            else if (m_data >= 0) begin
               e_rdy = slvHREADYOUT[m_data]; e_resp = slvHRESP[m_data]; e_rd = slvHRDATA[m_data];
            end
            chk("rnd_sel", slvHSEL, e_sel);
            chk("rnd_addr", slvHADDR, e_addr);
            chk("rnd_wr", slvHWRITE, e_wr);
            chk("rnd_wdata", slvHWDATA, mstHWDATA);
            chk("rnd_rdy", mstHREADYOUT, e_rdy);
            chk("rnd_slvrdy", slvHREADY, e_rdy);
            chk("rnd_resp", mstHRESP, e_resp);
            if (m_data >= 0 && !m_pend) chk("rnd_rdata", mstHRDATA, e_rd);
            if (!m_pend || granted[m_pt]) chk("rnd_trans", slvHTRANS, e_tr);
            if (!m_pend || m_hl || m_htr != SEQ) chk("rnd_cs", can_switch, e_cs);
            acc = e_rdy;
            @(posedge HCLK);
            if (e_rdy) begin
               m_data = -1; m_err = 0; m_pend = 0;
               if (mstHSEL && mstHTRANS[1]) begin
                  if (t < 0) m_err = 1;
                  else if (granted[t]) m_data = t;
                  else begin
                     m_pend = 1; m_pt = t; m_ha = mstHADDR; m_hw = mstHWRITE;
                     m_hl = mstHMASTLOCK; m_htr = mstHTRANS;
                  end
               end
            end else if (m_pend) begin
               if (granted[m_pt] && slvHREADYOUT[m_pt]) begin m_pend = 0; m_data = m_pt; end
            end else if (m_err == 1) begin
               m_err = 2;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
